// File: rtl/kb_ps2_pkg.sv
// kb_ps2_pkg: shared types and constants for the HID-report to PS/2 set-2 decoder.
//   state_t   : decoder FSM states
//   PS2_EXT   : extended-code prefix byte
//   PS2_BRK   : break prefix byte
//   MOD_TBL   : {ext, code} per modifier bit (bit0 LCtrl .. bit7 RGUI)
package kb_ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        POP,
        LOAD,
        SCAN_BRK,
        SCAN_MK,
        EMIT_E0,
        EMIT_F0,
        EMIT_CODE
    } state_t;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    // Eight modifier items followed by six usage slots.
    localparam logic [3:0] LAST_ITEM = 4'd13;

    // Index 0 is the rightmost entry: LCtrl, LShift, LAlt, LGUI, RCtrl, RShift, RAlt, RGUI.
    localparam logic [7:0][8:0] MOD_TBL = {
        9'h127, 9'h111, 9'h059, 9'h114, 9'h11F, 9'h011, 9'h012, 9'h014
    };

endpackage

// File: rtl/hid_to_ps2_rom.sv
// hid_to_ps2_rom: combinational HID keyboard usage to PS/2 set-2 make code lookup.
//   usage : HID usage ID
//   ps2   : {ext flag, make code}; code 0x00 means the usage has no entry
module hid_to_ps2_rom (
    input  logic [7:0] usage,
    output logic [8:0] ps2
);

    always_comb begin
        ps2 = 9'h000;
        case (usage)
            8'h04: ps2 = 9'h01C;
            8'h05: ps2 = 9'h032;
            8'h06: ps2 = 9'h021;
            8'h07: ps2 = 9'h023;
            8'h08: ps2 = 9'h024;
            8'h09: ps2 = 9'h02B;
            8'h0A: ps2 = 9'h034;
            8'h0B: ps2 = 9'h033;
            8'h0C: ps2 = 9'h043;
            8'h0D: ps2 = 9'h03B;
            8'h0E: ps2 = 9'h042;
            8'h0F: ps2 = 9'h04B;
            8'h10: ps2 = 9'h03A;
            8'h11: ps2 = 9'h031;
            8'h12: ps2 = 9'h044;
            8'h13: ps2 = 9'h04D;
            8'h14: ps2 = 9'h015;
            8'h15: ps2 = 9'h02D;
            8'h16: ps2 = 9'h01B;
            8'h17: ps2 = 9'h02C;
            8'h18: ps2 = 9'h03C;
            8'h19: ps2 = 9'h02A;
            8'h1A: ps2 = 9'h01D;
            8'h1B: ps2 = 9'h022;
            8'h1C: ps2 = 9'h035;
            8'h1D: ps2 = 9'h01A;
            8'h1E: ps2 = 9'h016;
            8'h1F: ps2 = 9'h01E;
            8'h20: ps2 = 9'h026;
            8'h21: ps2 = 9'h025;
            8'h22: ps2 = 9'h02E;
            8'h23: ps2 = 9'h036;
            8'h24: ps2 = 9'h03D;
            8'h25: ps2 = 9'h03E;
            8'h26: ps2 = 9'h046;
            8'h27: ps2 = 9'h045;
            8'h28: ps2 = 9'h05A;
            8'h29: ps2 = 9'h076;
            8'h2A: ps2 = 9'h066;
            8'h2B: ps2 = 9'h00D;
            8'h2C: ps2 = 9'h029;
            8'h2D: ps2 = 9'h04E;
            8'h2E: ps2 = 9'h055;
            8'h2F: ps2 = 9'h054;
            8'h30: ps2 = 9'h05B;
            8'h31: ps2 = 9'h05D;
            8'h33: ps2 = 9'h04C;
            8'h34: ps2 = 9'h052;
            8'h35: ps2 = 9'h00E;
            8'h36: ps2 = 9'h041;
            8'h37: ps2 = 9'h049;
            8'h38: ps2 = 9'h04A;
            8'h39: ps2 = 9'h058;
            8'h3A: ps2 = 9'h005;
            8'h3B: ps2 = 9'h006;
            8'h3C: ps2 = 9'h004;
            8'h3D: ps2 = 9'h00C;
            8'h3E: ps2 = 9'h003;
            8'h3F: ps2 = 9'h00B;
            8'h40: ps2 = 9'h083;
            8'h41: ps2 = 9'h00A;
            8'h42: ps2 = 9'h001;
            8'h43: ps2 = 9'h009;
            8'h44: ps2 = 9'h078;
            8'h45: ps2 = 9'h007;
            8'h49: ps2 = 9'h170;
            8'h4A: ps2 = 9'h16C;
            8'h4B: ps2 = 9'h17D;
            8'h4C: ps2 = 9'h171;
            8'h4D: ps2 = 9'h169;
            8'h4E: ps2 = 9'h17A;
            8'h4F: ps2 = 9'h174;
            8'h50: ps2 = 9'h16B;
            8'h51: ps2 = 9'h172;
            8'h52: ps2 = 9'h175;
            default: ps2 = 9'h000;
        endcase
    end

endmodule

// File: rtl/kb_report_decoder.sv
// kb_report_decoder: pops HID boot keyboard reports and emits PS/2 set-2 make/break bytes.
//   clk, reset_n           : clock, synchronous active-low reset
//   fifo_empty, fifo_rd_en : report queue status and one-cycle pop strobe
//   fifo_dout              : popped report, valid the cycle after the pop
//   ps2_data, ps2_valid    : scan code byte stream, held until ps2_ready
//   ps2_ready              : downstream accept
//   busy                   : decoder not idle
module kb_report_decoder
    import kb_ps2_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         fifo_empty,
    output logic         fifo_rd_en,
    input  logic [125:0] fifo_dout,
    output logic [7:0]   ps2_data,
    output logic         ps2_valid,
    input  logic         ps2_ready,
    output logic         busy
);

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [55:0] cur_q, cur_d, prev_q, prev_d;
    logic        brk_q, brk_d;
    logic [8:0]  item_q, item_d;

    logic [55:0] scan_rpt, oth_rpt;
    logic [7:0]  usage;
    logic [8:0]  rom_out, item;
    logic [3:0]  hi;
    logic        is_mod, present, in_oth, typematic, tm_mk, hit;
    logic        unused_hi;

    // Bytes above the six usage slots carry no key data.
    assign unused_hi = ^fifo_dout[125:56];

    hid_to_ps2_rom u_rom (
        .usage (usage),
        .ps2   (rom_out)
    );

    // Evaluate the scan item at idx_q: 0-7 modifier bits, 8-13 usage slots.
    always_comb begin
        scan_rpt  = brk_q ? prev_q : cur_q;
        oth_rpt   = brk_q ? cur_q : prev_q;
        is_mod    = ~idx_q[3];
        usage     = '0;
        for (int s = 0; s < 6; s++)
            if (idx_q == 4'(s + 8)) usage = scan_rpt[8 + 8*s +: 8];
        in_oth = 1'b0;
        hi     = '0;
        for (int s = 0; s < 6; s++) begin
            if (oth_rpt[8 + 8*s +: 8] == usage) in_oth = 1'b1;
            if (cur_q[8 + 8*s +: 8] != 8'd0) hi = 4'(s + 8);
        end
        if (is_mod) in_oth = oth_rpt[idx_q[2:0]];
        present   = is_mod ? scan_rpt[idx_q[2:0]] : (usage > 8'd1 && rom_out[7:0] != 8'd0);
        item      = is_mod ? MOD_TBL[idx_q[2:0]] : rom_out;
        typematic = (cur_q == prev_q) && (|cur_q);
        // A repeated report re-makes only the newest key; modifiers never repeat.
        tm_mk     = ~brk_q & typematic;
        hit       = present && (tm_mk ? (!is_mod && idx_q == hi) : !in_oth);
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cur_d      = cur_q;
        prev_d     = prev_q;
        brk_d      = brk_q;
        item_d     = item_q;
        fifo_rd_en = 1'b0;
        ps2_valid  = 1'b0;
        ps2_data   = 8'h00;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    // No pop while held in reset, so no report is lost.
                    fifo_rd_en = reset_n;
                    state_d    = POP;
                end
            end
            POP: state_d = LOAD;
            LOAD: begin
                cur_d   = fifo_dout[55:0];
                brk_d   = 1'b1;
                idx_d   = '0;
                state_d = SCAN_BRK;
            end
            SCAN_BRK, SCAN_MK: begin
                if (idx_q > LAST_ITEM) begin
                    idx_d   = '0;
                    brk_d   = 1'b0;
                    prev_d  = brk_q ? prev_q : cur_q;
                    state_d = brk_q ? SCAN_MK : IDLE;
                end else begin
                    idx_d = idx_q + 4'd1;
                    if (hit) begin
                        item_d  = item;
                        state_d = item[8] ? EMIT_E0 : (brk_q ? EMIT_F0 : EMIT_CODE);
                    end
                end
            end
            EMIT_E0: begin
                ps2_valid = 1'b1;
                ps2_data  = PS2_EXT;
                if (ps2_ready) state_d = brk_q ? EMIT_F0 : EMIT_CODE;
            end
            EMIT_F0: begin
                ps2_valid = 1'b1;
                ps2_data  = PS2_BRK;
                if (ps2_ready) state_d = EMIT_CODE;
            end
            EMIT_CODE: begin
                ps2_valid = 1'b1;
                ps2_data  = item_q[7:0];
                if (ps2_ready) state_d = brk_q ? SCAN_BRK : SCAN_MK;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cur_q   <= '0;
            prev_q  <= '0;
            brk_q   <= 1'b0;
            item_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cur_q   <= cur_d;
            prev_q  <= prev_d;
            brk_q   <= brk_d;
            item_q  <= item_d;
        end
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_kb_report_decoder.sv
// tb_kb_report_decoder: directed scoreboard bench for kb_report_decoder.
module tb_kb_report_decoder;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         fifo_empty = 1'b1;
    logic         fifo_rd_en;
    logic [125:0] fifo_dout = '0;
    logic [7:0]   ps2_data;
    logic         ps2_valid;
    logic         ps2_ready = 1'b1;
    logic         busy;

    logic [125:0] fq[$];
    logic [7:0]   exp_q[$];
    int           n_cmp = 0;
    int           n_err = 0;

    always #5 clk = ~clk;

    kb_report_decoder dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .fifo_dout  (fifo_dout),
        .ps2_data   (ps2_data),
        .ps2_valid  (ps2_valid),
        .ps2_ready  (ps2_ready),
        .busy       (busy)
    );

    // Report queue model: registered output that holds until the next pop.
    always @(posedge clk) begin
        if (fifo_rd_en && fq.size() != 0) fifo_dout <= fq.pop_front();
        fifo_empty <= (fq.size() == 0);
    end

    // Scoreboard: every accepted byte must be the next expected one.
    always @(negedge clk) begin
        logic [7:0] e;
        if (reset_n && ps2_valid && ps2_ready) begin
            e = 8'hxx;
            if (exp_q.size() != 0) e = exp_q.pop_front();
            n_cmp++;
            assert (ps2_data === e) else begin
                n_err++;
                $error("FAIL ps2_byte: observed %02h expected %02h", ps2_data, e);
            end
        end
        if (fifo_rd_en) begin
            n_cmp++;
            assert ((!fifo_empty && reset_n) === 1'b1) else begin
                n_err++;
                $error("FAIL pop_guard: observed empty=%0b reset_n=%0b expected 0/1", fifo_empty, reset_n);
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Queue a report and the bytes it must produce (bytes right-aligned, first byte leftmost).
    task automatic push(input logic [7:0] m, input logic [47:0] s, input int n, input logic [63:0] b);
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        fq.push_back({r[69:0], s, m});
        for (int i = 0; i < n; i++) exp_q.push_back(b[8*(n-1-i) +: 8]);
    endtask

    task automatic drain(input string tag);
        int c;
        c = 0;
        while (!(exp_q.size() == 0 && fq.size() == 0 && fifo_empty && !busy) && c < 3000) begin
            tick();
            c++;
        end
        chk(tag, 32'(c < 3000), 32'd1);
    endtask

    task automatic wait_valid(input string tag);
        int c;
        c = 0;
        while (!ps2_valid && c < 200) begin
            tick();
            c++;
        end
        chk(tag, 32'(c < 200), 32'd1);
    endtask

    initial begin
        push(8'h00, 48'h04, 1, 64'h1C);
        tick(3);
        chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        chk("rst_valid", 32'(ps2_valid), 32'd0);
        chk("rst_data", 32'(ps2_data), 32'h00);
        chk("rst_busy", 32'(busy), 32'd0);
        reset_n = 1'b1;
        push(8'h00, 48'h00, 2, 64'hF01C);
        drain("drain_a");

        push(8'h00, 48'h4F, 2, 64'hE074);
        push(8'h00, 48'h00, 3, 64'hE0F074);
        drain("drain_right");

        push(8'h02, 48'h04, 2, 64'h121C);
        push(8'h00, 48'h05, 5, 64'hF012F01C32);
        push(8'h00, 48'h00, 2, 64'hF032);
        drain("drain_shift");

        push(8'h00, 48'h0504, 2, 64'h1C32);
        push(8'h00, 48'h0504, 1, 64'h32);
        push(8'h00, 48'h00, 4, 64'hF01CF032);
        drain("drain_typematic");

        ps2_ready = 1'b0;
        push(8'h00, 48'h4F, 2, 64'hE074);
        push(8'h00, 48'h00, 3, 64'hE0F074);
        wait_valid("stall_wait");
        for (int i = 0; i < 10; i++) begin
            chk("stall_data", 32'(ps2_data), 32'hE0);
            chk("stall_valid", 32'(ps2_valid), 32'd1);
            chk("stall_rd_en", 32'(fifo_rd_en), 32'd0);
            tick();
        end
        ps2_ready = 1'b1;
        drain("drain_stall");

        push(8'h00, 48'hE80301, 0, 64'h0);
        push(8'h00, 48'h00, 0, 64'h0);
        drain("drain_skip");

        push(8'h01, 48'h00, 1, 64'h14);
        push(8'h01, 48'h00, 0, 64'h0);
        push(8'h00, 48'h00, 2, 64'hF014);
        drain("drain_mod_rep");

        push(8'h80, 48'h00, 2, 64'hE027);
        push(8'h00, 48'h00, 3, 64'hE0F027);
        drain("drain_rgui");

        push(8'h00, 48'h4F, 2, 64'hE074);
        drain("drain_pre_abort");
        ps2_ready = 1'b0;
        push(8'h00, 48'h00, 1, 64'hE0);
        wait_valid("abort_wait");
        chk("abort_e0", 32'(ps2_data), 32'hE0);
        ps2_ready = 1'b1;
        tick();
        ps2_ready = 1'b0;
        chk("abort_f0", 32'(ps2_data), 32'hF0);
        reset_n = 1'b0;
        tick();
        chk("abort_valid", 32'(ps2_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_data", 32'(ps2_data), 32'h00);
        reset_n = 1'b1;
        ps2_ready = 1'b1;
        tick(5);
        push(8'h00, 48'h00, 0, 64'h0);
        drain("drain_abort");

        push(8'h00, 48'h1A, 1, 64'h1D);
        drain("drain_w");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/kb_report_decoder.md
KB_REPORT_DECODER -- requirements
Module: kb_report_decoder

Interface
REQ-001 SHALL: clk  input  1  single clock; all logic on posedge clk.
REQ-002 SHALL: reset_n  input  1  reset, synchronous, active-low.
REQ-003 SHALL: fifo_empty  input  1  report queue empty flag.
REQ-004 SHALL: fifo_rd_en  output  1  one-cycle pop strobe to report queue.
REQ-005 SHALL: fifo_dout  input  126  popped report, valid the cycle after fifo_rd_en.
REQ-006 SHALL: ps2_data  output  8  PS/2 set-2 scan code byte.
REQ-007 SHALL: ps2_valid  output  1  ps2_data valid.
REQ-008 SHALL: ps2_ready  input  1  downstream accepts byte when ps2_valid && ps2_ready.
REQ-009 SHALL: busy  output  1  high in any state other than IDLE.

Function
REQ-010 SHALL: report layout is [7:0] modifier bitmap (bit0 LCtrl..bit7 RGUI), [55:8] six 8-bit HID usages (slot0 = [15:8]), [125:56] ignored.
REQ-011 SHALL: FSM states IDLE, POP, LOAD, SCAN_BRK, SCAN_MK, EMIT_E0, EMIT_F0, EMIT_CODE.
REQ-012 SHALL: IDLE with fifo_empty=0 -> fifo_rd_en=1 for exactly one cycle -> POP; POP -> LOAD; LOAD latches fifo_dout as cur_rpt.
REQ-013 SHALL: fifo_rd_en never asserted outside IDLE; no pop while fifo_empty=1.
REQ-014 SHALL: SCAN_BRK walks 14 items (8 modifier bits, then slots 0-5) of prev_rpt; item emits break if present in prev_rpt and absent from cur_rpt (usage compare against all six cur slots).
REQ-015 SHALL: SCAN_MK then walks the same 14 items of cur_rpt; item emits make if present in cur_rpt and absent from prev_rpt.
REQ-016 SHALL: usages 0x00 and 0x01 (rollover) and usages with no table entry (code 0x00) are skipped, no bytes.
REQ-017 SHALL: make sequence = [E0] code; break sequence = [E0] F0 code; E0 only when table extended flag set.
REQ-018 SHALL: typematic: cur_rpt == prev_rpt and non-zero -> emit make for highest-index non-zero slot only; if all slots zero, emit nothing.
REQ-019 SHALL: each EMIT state holds ps2_data/ps2_valid stable until ps2_ready; advance on handshake cycle; ps2_valid deasserted on return to scan.
REQ-020 SHALL: after SCAN_MK completes, prev_rpt <= cur_rpt, return to IDLE; at most one scan item examined per cycle.
REQ-021 SHALL: a report with both breaks and makes emits all breaks before any make.
REQ-022 SHALL: ps2_ready asserted with ps2_valid=0 has no effect.

Reset
REQ-023 SHALL: reset_n=0 -> state IDLE, fifo_rd_en=0, ps2_valid=0, ps2_data=0x00, busy=0, prev_rpt=0, scan index=0.
REQ-024 SHALL: reset mid-emission aborts the sequence immediately; no further bytes of that sequence are emitted after release.

Structure
REQ-025 SHALL: package kb_ps2_pkg holds state enum, modifier-to-scan-code constant table (12, 14, 11, E0 1F, E0 14, 59, E0 11, E0 27 for bits 1,0,2,3,4,5,6,7 respectively by name), and PS2_EXT=0xE0, PS2_BRK=0xF0.
REQ-026 SHALL: sub-module hid_to_ps2_rom, combinational, 8-bit usage in -> {ext flag, 8-bit code} out, instanced once.

Verification
REQ-027 SHALL: report slot0=0x04 from zero prev -> single byte 0x1C; then all-zero report -> 0xF0, 0x1C.
REQ-028 SHALL: slot0=0x4F (Right) press/release -> 0xE0, 0x74 then 0xE0, 0xF0, 0x74.
REQ-029 SHALL: modifier 0x02 plus slot0=0x04 -> 0x12, 0x1C in that order; next report slot0=0x05 only -> 0xF0, 0x12, 0xF0, 0x1C, 0x32.
REQ-030 SHALL: identical report slot0=0x04, slot1=0x05 pushed twice -> second pop yields only 0x32.
REQ-031 SHALL: ps2_ready held low 10 cycles during 0xE0 -> ps2_data=0xE0, ps2_valid=1 constant; no extra fifo_rd_en.
REQ-032 SHALL: reset_n low during EMIT_F0 -> next cycle ps2_valid=0, state IDLE, prev_rpt=0.
